// File: rtl/hexdisp_scan_ctrl.sv
// hexdisp_scan_ctrl: tear-free multiplexed 7-segment scan controller with blanking and leading-zero suppression
module hexdisp_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_lz_suppress,
  output logic [3:0]              o_bin_num,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_start,
  output logic                    o_load_ack,
  output logic                    o_pending
);
  localparam int KW = $clog2(NUM_DIGITS);
  localparam int CMAX = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX);
  localparam logic POL = DIGIT_ACTIVE_LOW != 0;
  localparam logic [NUM_DIGITS-1:0] OFF = {NUM_DIGITS{POL}};
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, nstate;
  logic [KW-1:0] k, nk;
  logic [CW-1:0] cnt, ncnt;
  logic [4*NUM_DIGITS-1:0] shadow, nshadow, pend_val;
  logic lz, nlz, blank_end, show_end, wrap;
  logic [NUM_DIGITS-1:0] supp, sel;
  always_comb begin
    blank_end = state == BLANK && cnt == CW'(BLANK_CYCLES - 1);
    show_end = state == SHOW && cnt == CW'(REFRESH_DIV - 1);
    wrap = show_end && k == KW'(NUM_DIGITS - 1);
    nstate = blank_end ? SHOW : show_end ? BLANK : state;
    ncnt = (blank_end || show_end) ? '0 : cnt + 1'b1;
    nk = show_end ? (wrap ? '0 : k + 1'b1) : k;
    nshadow = (wrap && o_pending) ? pend_val : shadow;
    nlz = wrap ? i_lz_suppress : lz;
    supp = '0;
    for (int j = 1; j < NUM_DIGITS; j++)
      supp[j] = nlz && (nshadow >> (4 * j)) == '0;
    sel = (nstate == SHOW && !supp[nk]) ? OFF ^ (NUM_DIGITS'(1) << nk) : OFF;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= BLANK;
      k <= '0;
      cnt <= '0;
      shadow <= '0;
      pend_val <= '0;
      lz <= 1'b0;
      o_pending <= 1'b0;
      o_bin_num <= '0;
      o_digit_en <= OFF;
      o_frame_start <= 1'b0;
      o_load_ack <= 1'b0;
    end else begin
      state <= nstate;
      k <= nk;
      cnt <= ncnt;
      shadow <= nshadow;
      lz <= nlz;
      o_pending <= i_load || (o_pending && !wrap);
      if (i_load) pend_val <= i_value;
      o_bin_num <= 4'(nshadow >> (4 * nk));
      o_digit_en <= sel;
      o_frame_start <= wrap;
      o_load_ack <= wrap && o_pending;
    end
  end
endmodule

// File: tb/tb_hexdisp_scan_ctrl.sv
// tb_hexdisp_scan_ctrl: vector table, corner sequences and random loads against a frame-timing reference model
module tb_hexdisp_scan_ctrl;
  localparam int ND = 4, RD = 8, BC = 2, SL = RD + BC, FR = ND * SL;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] bin, en;
  logic fs, ack, pend;
  int compared = 0, mismatched = 0, t = 0, blank_run = 0;
  logic [15:0] m_sh = '0, m_pv = '0, prev_sh = '0;
  logic m_pend = 1'b0, m_lz = 1'b0, m_fs = 1'b0, m_ack = 1'b0;
  logic [3:0] prev_en = 4'hF;
  typedef struct {
    int t;
    logic ld;
    logic [15:0] val;
    logic [3:0] bin;
    logic [3:0] en;
    logic fs;
    logic ack;
    logic pend;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  hexdisp_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DIGIT_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load), .i_lz_suppress(lz),
    .o_bin_num(bin), .o_digit_en(en), .o_frame_start(fs), .o_load_ack(ack), .o_pending(pend)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, a, e);
    end
  endtask
  function automatic logic [3:0] exp_bin();
    int slot;
    slot = (t % FR) / SL;
    return 4'(m_sh >> (4 * slot));
  endfunction
  function automatic logic [3:0] exp_en();
    int slot, off;
    logic sup;
    slot = (t % FR) / SL;
    off = (t % FR) % SL;
    sup = slot > 0 && m_lz && (m_sh >> (4 * slot)) == 16'h0;
    return (off < BC || sup) ? 4'hF : ~(4'b0001 << slot);
  endfunction
  task automatic check_model();
    chk("bin", bin, exp_bin());
    chk("digit_en", en, exp_en());
    chk("frame_start", fs, m_fs);
    chk("load_ack", ack, m_ack);
    chk("pending", pend, m_pend);
    chk("onehot", $countones(~en) <= 1, 1);
    if (en != 4'hF && en != prev_en) chk("blank_gap", prev_en == 4'hF && blank_run >= BC, 1);
    blank_run = (en == 4'hF) ? blank_run + 1 : 0;
    prev_en = en;
    if (dut.shadow != prev_sh) chk("shadow_hold", fs, 1);
    prev_sh = dut.shadow;
  endtask
  task automatic step();
    @(posedge clk);
    t++;
    m_fs = (t % FR == 0);
    m_ack = m_fs && m_pend;
    if (m_fs) begin
      if (m_pend) m_sh = m_pv;
      m_lz = lz;
      m_pend = 1'b0;
    end
    if (load) begin
      m_pend = 1'b1;
      m_pv = value;
    end
    #1;
    load = 1'b0;
    check_model();
  endtask
  task automatic run_to(input int n);
    while (t < n) step();
  endtask
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    m_sh = '0; m_pv = '0; m_pend = 1'b0; m_lz = 1'b0; m_fs = 1'b0; m_ack = 1'b0;
    prev_en = 4'hF; blank_run = 0; prev_sh = '0;
    check_model();
  endtask
  task automatic load_now(input logic [15:0] v);
    load = 1'b1;
    value = v;
    step();
  endtask
  initial begin
    vecs.push_back('{0, 1'b1, 16'h1234, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1, 1'b0, 16'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{2, 1'b0, 16'h0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{39, 1'b0, 16'h0, 4'h0, 4'h7, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{40, 1'b0, 16'h0, 4'h4, 4'hF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{42, 1'b0, 16'h0, 4'h4, 4'hE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{45, 1'b1, 16'hAAAA, 4'h4, 4'hE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{46, 1'b0, 16'h0, 4'h4, 4'hE, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{50, 1'b0, 16'h0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{52, 1'b0, 16'h0, 4'h3, 4'hD, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{60, 1'b1, 16'h00F0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{62, 1'b0, 16'h0, 4'h2, 4'hB, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{72, 1'b0, 16'h0, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{79, 1'b0, 16'h0, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{80, 1'b0, 16'h0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{90, 1'b0, 16'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{92, 1'b0, 16'h0, 4'hF, 4'hD, 1'b0, 1'b0, 1'b0});
    release_reset();
    foreach (vecs[i]) begin
      run_to(vecs[i].t);
      chk($sformatf("vec%0d_bin", i), bin, vecs[i].bin);
      chk($sformatf("vec%0d_en", i), en, vecs[i].en);
      chk($sformatf("vec%0d_fs", i), fs, vecs[i].fs);
      chk($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
      chk($sformatf("vec%0d_pend", i), pend, vecs[i].pend);
      if (vecs[i].ld) begin
        load = 1'b1;
        value = vecs[i].val;
      end
    end
    run_to(100);
    load_now(16'h7777);
    run_to(119);
    load_now(16'h5555);
    chk("coinc_fs", fs, 1);
    chk("coinc_ack", ack, 1);
    chk("coinc_pend", pend, 1);
    chk("coinc_bin", bin, 4'h7);
    run_to(160);
    chk("next_ack", ack, 1);
    chk("next_bin", bin, 4'h5);
    chk("next_pend", pend, 0);
    lz = 1'b1;
    run_to(165);
    load_now(16'h0050);
    run_to(202);
    chk("lz_d0_en", en, 4'hE);
    run_to(212);
    chk("lz_d1_en", en, 4'hD);
    chk("lz_d1_bin", bin, 4'h5);
    run_to(222);
    chk("lz_d2_en", en, 4'hF);
    run_to(232);
    chk("lz_d3_en", en, 4'hF);
    chk("lz_d3_bin", bin, 4'h0);
    run_to(235);
    load_now(16'h0000);
    run_to(242);
    chk("zero_d0_en", en, 4'hE);
    chk("zero_d0_bin", bin, 4'h0);
    run_to(252);
    chk("zero_d1_en", en, 4'hF);
    run_to(272);
    chk("zero_d3_en", en, 4'hF);
    lz = 1'b0;
    run_to(290);
    load_now(16'h9999);
    run_to(304);
    chk("pre_rst_pend", pend, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", en, 4'hF);
    chk("async_rst_pend", pend, 0);
    chk("async_rst_bin", bin, 4'h0);
    release_reset();
    run_to(2);
    chk("restart_en", en, 4'hE);
    chk("restart_bin", bin, 4'h0);
    for (int i = 0; i < 10 * FR; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load = 1'b1;
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      end
      if (t % FR == FR - 2) lz = 1'($urandom_range(0, 1));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
